hs_rx_buffer: RTL and testbench

- Responder end of the four-phase req/ack cross-clock handshake used between the clk_a data driver and the clk_b consumer.
- Lives entirely in clk_b and does three things:
  - synchronises data_req;
  - captures data and returns data_ack;
  - queues captured words in a small first-word-fall-through FIFO with a valid/ready output.
- Withholds data_ack while the FIFO is full, which gives end-to-end backpressure to the sender.

---
 rtl/hs_pkg.sv | 24 ++
 rtl/sync_bit.sv | 25 ++
 rtl/hs_rx_buffer.sv | 137 +++++++++++++
 tb/tb_hs_rx_buffer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/hs_pkg.sv
// rtl/hs_pkg.sv - shared types, widths and helpers for the req/ack receive buffer
package hs_pkg;

  localparam int HS_DATA_W_DEFAULT = 4;

  typedef enum logic [1:0] {
    RESYNC = 2'd0,
    IDLE   = 2'd1,
    ACK    = 2'd2
  } hs_rx_state_t;

  // Ceiling log2 usable in parameter expressions; returns 0 for values <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/sync_bit.sv
// rtl/sync_bit.sv - multi-flop single-bit synchroniser with configurable reset value
module sync_bit #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_chain;

  // Shift the asynchronous input through the chain; only the first flop sees d.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain <= {r_chain[STAGES-2:0], d};
    end
  end

  assign q = r_chain[STAGES-1];

endmodule

// File: rtl/hs_rx_buffer.sv
// rtl/hs_rx_buffer.sv - req/ack handshake responder feeding a first-word-fall-through FIFO
module hs_rx_buffer
  import hs_pkg::*;
#(
  parameter int DATA_W      = HS_DATA_W_DEFAULT,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2,
  localparam int PTR_W      = clog2(DEPTH),
  localparam int LVL_W      = clog2(DEPTH + 1)
) (
  input  logic              clk_b,
  input  logic              rst,
  input  logic              data_req,
  input  logic [DATA_W-1:0] data,
  output logic              data_ack,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [LVL_W-1:0]  fill_level
);

  logic              w_req_s;
  hs_rx_state_t      r_state;
  hs_rx_state_t      w_state_nxt;
  logic              r_ack;
  logic              w_ack_nxt;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [PTR_W-1:0]  r_wptr;
  logic [PTR_W-1:0]  r_rptr;
  logic [LVL_W-1:0]  r_level;
  logic [DATA_W-1:0] r_mem [DEPTH];

  // Reset to 1 so a request that straddles reset looks still-asserted and RESYNC waits it out.
  sync_bit #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_req_sync (
    .clk (clk_b),
    .rst (rst),
    .d   (data_req),
    .q   (w_req_s)
  );

  // Full/empty come from the registered level only, so a pop cannot unblock capture on the same edge.
  assign w_full  = (r_level == LVL_W'(DEPTH));
  assign w_empty = (r_level == '0);
  assign w_pop   = out_ready && !w_empty;

  // Handshake state and registered acknowledge.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_state <= RESYNC;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ack   <= w_ack_nxt;
    end
  end

  // Next-state logic; a word is written only on the IDLE->ACK transition.
  always_comb begin
    w_state_nxt = r_state;
    w_ack_nxt   = r_ack;
    w_push      = 1'b0;
    case (r_state)
      RESYNC: begin
        w_ack_nxt = 1'b0;
        if (!w_req_s) begin
          w_state_nxt = IDLE;
        end
      end
      IDLE: begin
        w_ack_nxt = 1'b0;
        if (w_req_s && !w_full) begin
          w_push      = 1'b1;
          w_ack_nxt   = 1'b1;
          w_state_nxt = ACK;
        end
      end
      ACK: begin
        w_ack_nxt = 1'b1;
        if (!w_req_s) begin
          w_ack_nxt   = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ack_nxt   = 1'b0;
        w_state_nxt = RESYNC;
      end
    endcase
  end

  // Storage array; contents are meaningful only between rptr and wptr, so no reset.
  always_ff @(posedge clk_b) begin
    if (w_push) begin
      r_mem[r_wptr] <= data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PTR_W'(1);
      end
    end
  end

  // Occupancy count; simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk_b) begin
    if (rst) begin
      r_level <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign data_ack   = r_ack;
  assign out_valid  = !w_empty;
  assign out_data   = w_empty ? '0 : r_mem[r_rptr];
  assign fill_level = r_level;

endmodule

// File: tb/tb_hs_rx_buffer.sv
// tb/tb_hs_rx_buffer.sv - scoreboard bench for the req/ack receive buffer
module tb_hs_rx_buffer;

  localparam int DATA_W = 4;
  localparam int DEPTH  = 4;
  localparam int LVL_W  = 3;

  logic              clk_b = 1'b0;
  logic              rst;
  logic              data_req;
  logic [DATA_W-1:0] data;
  logic              data_ack;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [LVL_W-1:0]  fill_level;

  int checks   = 0;
  int failures = 0;
  int max_fill = 0;
  int pops     = 0;
  logic [DATA_W-1:0] exp_q[$];

  hs_rx_buffer #(
    .DATA_W      (DATA_W),
    .DEPTH       (DEPTH),
    .SYNC_STAGES (2)
  ) dut (
    .clk_b      (clk_b),
    .rst        (rst),
    .data_req   (data_req),
    .data       (data),
    .data_ack   (data_ack),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .fill_level (fill_level)
  );

  always #5 clk_b = ~clk_b;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_b);
    #1;
  endtask

  // Scoreboard: every word accepted by the consumer must match the oldest word sent.
  always @(negedge clk_b) begin
    if (!rst) begin
      if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
      if (out_valid && out_ready) begin
        pops++;
        if (exp_q.size() == 0) begin
          check("sb_size", 0, 1);
        end else begin
          check("sb_data", out_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic send(input logic [DATA_W-1:0] w);
    int n;
    data     = w;
    data_req = 1'b1;
    exp_q.push_back(w);
    n = 0;
    while (!data_ack && n < 50) begin
      tick();
      n++;
    end
    check("ack_rise", data_ack, 1);
    data_req = 1'b0;
    n = 0;
    while (data_ack && n < 50) begin
      tick();
      n++;
    end
    check("ack_fall", data_ack, 0);
  endtask

  task automatic drain();
    int n;
    out_ready = 1'b1;
    n = 0;
    while (fill_level != 0 && n < 50) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("drain_empty", fill_level, 0);
  endtask

  initial begin
    rst       = 1'b1;
    data_req  = 1'b0;
    data      = '0;
    out_ready = 1'b0;
    tick();
    tick();
    check("rst_ack", data_ack, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_level", fill_level, 0);
    rst = 1'b0;
    repeat (4) tick();

    // 1: single transfer latency
    data     = 4'hA;
    data_req = 1'b1;
    exp_q.push_back(4'hA);
    tick();
    check("t1_ack_e1", data_ack, 0);
    tick();
    check("t1_ack_e2", data_ack, 0);
    tick();
    check("t1_ack_e3", data_ack, 1);
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 4'hA);
    check("t1_level", fill_level, 1);
    data_req = 1'b0;
    tick();
    check("t1_fall_e1", data_ack, 1);
    tick();
    check("t1_fall_e2", data_ack, 1);
    tick();
    check("t1_fall_e3", data_ack, 0);
    check("t1_level_hold", fill_level, 1);
    drain();

    // 2: backpressure at full
    for (int i = 1; i <= 4; i++) send(DATA_W'(i));
    check("t2_full", fill_level, 4);
    data     = 4'h5;
    data_req = 1'b1;
    exp_q.push_back(4'h5);
    repeat (10) tick();
    check("t2_stall_ack", data_ack, 0);
    check("t2_stall_level", fill_level, 4);
    check("t2_head", out_data, 1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t2_pop_level", fill_level, 3);
    check("t2_pop_noack", data_ack, 0);
    check("t2_new_head", out_data, 2);
    tick();
    check("t2_cap_ack", data_ack, 1);
    check("t2_cap_level", fill_level, 4);
    data_req = 1'b0;
    repeat (4) tick();
    check("t2_ack_low", data_ack, 0);
    drain();

    // 3: push and pop on the same edge
    send(4'hB);
    send(4'hC);
    check("t3_pre_level", fill_level, 2);
    data     = 4'hD;
    data_req = 1'b1;
    exp_q.push_back(4'hD);
    tick();
    tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("t3_cap_ack", data_ack, 1);
    check("t3_level", fill_level, 2);
    data_req = 1'b0;
    repeat (4) tick();
    drain();

    // 4: reset in the middle of a handshake
    send(4'h8);
    send(4'h9);
    data     = 4'h6;
    data_req = 1'b1;
    repeat (3) tick();
    check("t4_in_ack", data_ack, 1);
    check("t4_level3", fill_level, 3);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
    check("t4_rst_ack", data_ack, 0);
    check("t4_rst_valid", out_valid, 0);
    check("t4_rst_level", fill_level, 0);
    repeat (8) tick();
    check("t4_hold_ack", data_ack, 0);
    check("t4_hold_level", fill_level, 0);
    data_req = 1'b0;
    repeat (5) tick();
    send(4'h7);
    check("t4_one_entry", fill_level, 1);
    check("t4_data", out_data, 4'h7);
    drain();

    // 5: streaming with the consumer always ready, pointers wrap
    max_fill  = 0;
    pops      = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) send(DATA_W'(i));
    repeat (3) tick();
    out_ready = 1'b0;
    check("t5_max_fill", max_fill, 1);
    check("t5_pops", pops, 10);
    check("t5_sb_empty", exp_q.size(), 0);

    // 6: pops while empty are ignored
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_level", fill_level, 0);
      check("t6_data", out_data, 0);
    end
    out_ready = 1'b0;
    send(4'h3);
    check("t6_ptr_head", out_data, 4'h3);
    check("t6_ptr_level", fill_level, 1);
    drain();
    check("end_sb_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
